shift_right_ctrl: RTL and testbench
===================================

Name: shift_right_ctrl

Overview:
Sequencer that loads a parallel word into the team's 8-bit serial-in shift-right register (ports in, en, Q, clk).
- Accepts a word over a start/ready handshake.
- Drives the register's serial input and shift enable for exactly W cycles, LSB first, so that Q equals the word when done pulses.
- Sits between a parallel producer and the shift register; one transfer in flight at a time.

Parameters:
W, 8, word width and shift count; must match the downstream register width (W >= 2).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to transfer data_in; accepted when start && ready.
data_in  input  W  word to load; sampled only on the acceptance edge.
abort  input  1  cancel an in-flight transfer.
ready  output  1  high in IDLE only.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse after the last shift edge.
sr_in  output  1  serial bit to the shift register's in.
sr_en  output  1  shift enable to the shift register's en.
bit_cnt  output  $clog2(W+1)  number of bits shifted so far in the current transfer.

Behaviour:
- Downstream contract: on a clk edge with en=1, Q <= {in, Q[W-1:1]}. After W shifts, the first bit driven sits at Q[0].
- All outputs are registered.
- Reset values: ready=1, busy=0, done=0, sr_in=0, sr_en=0, bit_cnt=0, internal shadow word=0, state=IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, sr_en=0.
  - On start=1, latch data_in into the shadow, bit_cnt<=0 and move to SHIFT.
  - start is ignored when not in IDLE (no queueing).
- SHIFT:
  - sr_en=1 and sr_in=shadow[bit_cnt] in every SHIFT cycle; LSB goes first.
  - bit_cnt increments each cycle.
  - When bit_cnt reaches W-1, the next state is DONE.
  - SHIFT lasts exactly W cycles.
- DONE:
  - done=1 and sr_en=0 for one cycle, bit_cnt holds W, then return to IDLE.
  - A start asserted during DONE is not accepted; it is accepted the following cycle in IDLE.
- Latency:
  - Acceptance edge at cycle 0; sr_en high in cycles 1..W.
  - done high in cycle W+1; ready returns in cycle W+2.
  - Throughput: one word per W+2 cycles.
- abort:
  - In SHIFT: next state IDLE, sr_en=0 next cycle, no done pulse, bit_cnt<=0.
  - Downstream Q is left partially shifted; this is not this block's concern.
  - abort is ignored in IDLE and DONE.
  - abort and start together in IDLE: start wins (abort ignored).
- rst has priority over every input, including mid-SHIFT: outputs return to reset values on the next edge and sr_en deasserts immediately after that edge.
- data_in changes after acceptance have no effect on the transfer.

Optional Feature:
Macro SHIFT_RIGHT_CTRL_VERIFY_EN.
- When defined:
  - Adds input sr_q [W] (the register's Q) and output err [1].
  - In DONE, compare sr_q to the shadow; err <= (sr_q != shadow).
  - err holds until the next acceptance edge or rst, which clear it to 0.
  - The comparison happens in DONE, one cycle after the last shift edge, so the register's Q is stable.
- When not defined: no sr_q or err ports, and no compare logic.

Test Plan:
1. rst=1 for 2 cycles, then release → ready=1, busy=0, sr_en=0, done=0, bit_cnt=0.
2. start with data_in=8'hB2 → sr_en high 8 cycles, sr_in sequence 0,1,0,0,1,1,0,1; done one cycle later; attached register Q=8'hB2; total 10 cycles until ready=1.
3. Back-to-back: 8'hFF, then start held high; data_in=8'h01 presented from DONE onward → second word accepted the cycle after DONE (not in DONE); final Q=8'h01; no overlap of sr_en between words.
4. abort after 3 shift cycles of 8'hA5 → sr_en low next cycle, no done pulse, ready=1; a following start with 8'h3C still yields Q=8'h3C after a full 8 shifts.
5. rst asserted in SHIFT cycle 5 → all outputs equal reset values after that edge; start ignored while rst=1; start with data_in=8'h00 after release runs a full 8-cycle transfer.
6. SHIFT_RIGHT_CTRL_VERIFY_EN, register Q[3] forced stuck at 0, load 8'h0F → err=1 after DONE. Then load 8'h00 → err=0 from the acceptance edge onward and 0 after DONE.

Source files
------------

// File: rtl/shift_right_ctrl.sv
// -----------------------------------------------------------------------------
// shift_right_ctrl
//
// Loads a parallel word into a downstream W-bit serial-in shift-right register
// (Q <= {in, Q[W-1:1]} on every edge with en=1). A word is taken over a
// start/ready handshake. The block then drives the register's serial input
// and shift enable for exactly W cycles, LSB first, so Q equals the word by
// the time done pulses. Only one transfer is in flight at a time.
//
// Timing (edge numbers relative to the acceptance edge, which is edge 0):
//   sr_en is high in the period after edge 0 up to edge W-1, so the register
//   shifts on edges 1..W. done is high after edge W, and ready returns after
//   edge W+1. The next word can be accepted on edge W+2.
//
// Optional feature (macro SHIFT_RIGHT_CTRL_VERIFY_EN):
//   Adds input sr_q (the register's Q) and output err. In DONE the register
//   contents are compared with the word that was sent. err holds until the
//   next acceptance edge or rst.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   transfer request, accepted when start && ready
//   data_in  in   [W] word to load, sampled on the acceptance edge only
//   abort    in   cancels a transfer that is in SHIFT
//   sr_q     in   [W] downstream Q (VERIFY_EN builds only)
//   err      out  readback mismatch flag (VERIFY_EN builds only)
//   ready    out  high in IDLE
//   busy     out  high in SHIFT
//   done     out  one-cycle pulse after the last shift edge
//   sr_in    out  serial bit to the register's in
//   sr_en    out  shift enable to the register's en
//   bit_cnt  out  [$clog2(W+1)] bits shifted so far in this transfer
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module shift_right_ctrl #(
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [W-1:0]             data_in,
    input  logic                     abort,
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
    input  logic [W-1:0]             sr_q,
    output logic                     err,
`endif
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic                     sr_in,
    output logic                     sr_en,
    output logic [$clog2(W+1)-1:0]   bit_cnt
);

    localparam int CW = $clog2(W+1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   shadow;
    logic [W-1:0]   shadow_nxt;
    logic [CW-1:0]  cnt_nxt;
    logic           ready_nxt;
    logic           busy_nxt;
    logic           done_nxt;
    logic           sr_in_nxt;
    logic           sr_en_nxt;
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
    logic           err_nxt;
`endif

    // Select one bit of the word by counter value. Written as a compare loop
    // so the counter (one bit wider than a bit index) never indexes directly.
    function automatic logic pick_bit(input logic [W-1:0] word,
                                      input logic [CW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (idx == CW'(i)) begin
                b = word[i];
            end
        end
        return b;
    endfunction

    // Next-state and next-output logic. Outputs are computed here for the
    // state being entered, then registered, so sr_in always reflects
    // shadow[bit_cnt] while in SHIFT.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        cnt_nxt    = bit_cnt;
        ready_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        sr_in_nxt  = 1'b0;
        sr_en_nxt  = 1'b0;
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
        err_nxt    = err;
`endif

        case (state)
            ST_IDLE: begin
                // start beats abort here; abort has no meaning in IDLE.
                if (start) begin
                    state_nxt  = ST_SHIFT;
                    shadow_nxt = data_in;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
                    sr_en_nxt  = 1'b1;
                    sr_in_nxt  = data_in[0];
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
                    err_nxt    = 1'b0;
`endif
                end else begin
                    ready_nxt = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    // Downstream Q is left partially shifted on purpose.
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                end else if (bit_cnt == CW'(W - 1)) begin
                    // The last shift edge is the one leaving this cycle.
                    state_nxt = ST_DONE;
                    cnt_nxt   = CW'(W);
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = bit_cnt + CW'(1);
                    busy_nxt  = 1'b1;
                    sr_en_nxt = 1'b1;
                    sr_in_nxt = pick_bit(shadow, bit_cnt + CW'(1));
                end
            end

            ST_DONE: begin
                // start is not accepted here; ready rises on leaving DONE.
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
                // Q settled on the previous edge, so it is safe to compare.
                err_nxt   = (sr_q != shadow);
`endif
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers; rst overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shadow  <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sr_in   <= 1'b0;
            sr_en   <= 1'b0;
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            bit_cnt <= cnt_nxt;
            ready   <= ready_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            sr_in   <= sr_in_nxt;
            sr_en   <= sr_en_nxt;
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
            err     <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_shift_right_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_right_ctrl
//
// Directed bench for shift_right_ctrl (W=8) driving a behavioural model of the
// downstream 8-bit serial-in shift-right register. Expected values are written
// out by hand per vector.
// -----------------------------------------------------------------------------
module tb_shift_right_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   data_in;
    logic           abort;
    logic           ready;
    logic           busy;
    logic           done;
    logic           sr_in;
    logic           sr_en;
    logic [CW-1:0]  bit_cnt;
    logic [W-1:0]   q;
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
    logic [W-1:0]   sr_q;
    logic           err;
    assign sr_q = q & 8'hF7;   // Q[3] stuck at 0
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    shift_right_ctrl #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .abort   (abort),
`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
        .sr_q    (sr_q),
        .err     (err),
`endif
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .sr_in   (sr_in),
        .sr_en   (sr_en),
        .bit_cnt (bit_cnt)
    );

    // Downstream register: Q <= {in, Q[W-1:1]} when en.
    always_ff @(posedge clk) begin
        if (sr_en) q <= {sr_in, q[W-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"},   ready,   1);
        chk({tag, ".busy"},    busy,    0);
        chk({tag, ".sr_en"},   sr_en,   0);
        chk({tag, ".done"},    done,    0);
        chk({tag, ".sr_in"},   sr_in,   0);
        chk({tag, ".bit_cnt"}, bit_cnt, 0);
    endtask

    // Checks the W shift cycles that follow an acceptance edge and the DONE
    // cycle; leaves the bench in DONE.
    task automatic check_shift(input string tag, input logic [W-1:0] word);
        for (int i = 0; i < W; i++) begin
            chk({tag, ".sr_en"},   sr_en,   1);
            chk({tag, ".busy"},    busy,    1);
            chk({tag, ".ready"},   ready,   0);
            chk({tag, ".sr_in"},   sr_in,   word[i]);
            chk({tag, ".bit_cnt"}, bit_cnt, i);
            tick();
        end
        chk({tag, ".done"},     done,    1);
        chk({tag, ".sr_en_d"},  sr_en,   0);
        chk({tag, ".cnt_d"},    bit_cnt, W);
        chk({tag, ".ready_d"},  ready,   0);
        chk({tag, ".q"},        q,       word);
    endtask

    // Full transfer from IDLE back to IDLE; data_in is scrambled right after
    // acceptance to show it is not re-sampled.
    task automatic run_word(input string tag, input logic [W-1:0] word);
        data_in = word;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = ~word;
        check_shift(tag, word);
        tick();
        chk({tag, ".ready_i"}, ready, 1);
        chk({tag, ".done_i"},  done,  0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = '0;

        // 1: reset
        tick();
        tick();
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        tick();
        chk_reset_vals("rst_rel");

        // 2: single word, sr_in sequence 0,1,0,0,1,1,0,1
        run_word("b2", 8'hB2);

        // 3: back-to-back with start held high
        data_in = 8'hFF;
        start   = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            chk("ff.sr_en", sr_en, 1);
            chk("ff.sr_in", sr_in, 1);
            tick();
        end
        data_in = 8'h01;
        chk("ff.done", done, 1);
        chk("ff.q",    q,    8'hFF);
        tick();
        chk("b2b.not_in_done", busy,  0);
        chk("b2b.ready",       ready, 1);
        chk("b2b.gap_sr_en",   sr_en, 0);
        tick();
        start = 1'b0;
        check_shift("b2b01", 8'h01);
        tick();
        chk("b2b.ready_end", ready, 1);

        // 4: abort after three shift edges
        data_in = 8'hA5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        tick();
        chk("ab.cnt3", bit_cnt, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab.sr_en", sr_en,   0);
        chk("ab.done",  done,    0);
        chk("ab.ready", ready,   1);
        chk("ab.cnt",   bit_cnt, 0);
        tick();
        chk("ab.no_done", done, 0);
        run_word("3c", 8'h3C);

        // 5: reset in the middle of SHIFT, start held during reset
        data_in = 8'h5A;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("mid.cnt4", bit_cnt, 4);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        tick();
        chk_reset_vals("rst_start");
        rst   = 1'b0;
        start = 1'b0;
        tick();
        run_word("00", 8'h00);

`ifdef SHIFT_RIGHT_CTRL_VERIFY_EN
        // 6: readback with Q[3] stuck at 0
        run_word("v0f", 8'h0F);
        chk("v.err_set", err, 1);
        data_in = 8'h00;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("v.err_clr", err, 0);
        check_shift("v00", 8'h00);
        tick();
        chk("v.err_ok", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
